pixel_frame_sequencer: RTL
==========================

// Module: pixel_frame_sequencer
// PURPOSE
//  - Frame-level controller for the 4-group pixel array: sequences erase -> expose -> convert -> read0..read3.
//  - Replaces the free-running fixed-count state machine in the sensor top.
//  - During convert it generates the ADC digital ramp and drives it onto the pixel data bus.
//  - During each read phase it samples the bus and hands the sample to a downstream consumer over valid/ready.
// PARAMETERS
//  C_ERASE     5    erase strobe length, cycles (>=1)
//  C_CONVERT   255  convert length, cycles (1..256)
//  C_READ      5    read-phase settle time before sampling, cycles (>=1)
//  DW          8    pixel data / ramp width
// PORTS
//  clk          in   1      system clock, all logic on posedge
//  reset        in   1      asynchronous, active-low reset (asserted when 0)
//  start        in   1      begin one frame; accepted only in IDLE
//  abort        in   1      abandon frame, return to IDLE
//  expose_len   in   16     exposure cycles, sampled when start is accepted
//  busy         out  1      high in every state except IDLE
//  done         out  1      1-cycle pulse after the last read is accepted
//  erase        out  1      pixel array erase strobe
//  expose       out  1      pixel array expose strobe
//  convert      out  1      convert strobe; the top gates the analog ramp clock with it
//  read         out  4      one-hot read0..read3 strobes
//  bus_oe       out  1      drive enable for the pixel data bus (= convert)
//  bus_dout     out  DW     ramp value driven onto the bus
//  bus_din      in   DW     bus value as seen by the controller
//  pix_valid    out  1      captured sample available
//  pix_ready    in   1      consumer accepts the sample
//  pix_data     out  DW     captured sample
//  pix_group    out  2      read group index of pix_data
// BEHAVIOUR
//  - Reset (reset=0): state=IDLE; every output 0; counters 0.
//  - States: IDLE, ERASE, EXPOSE, CONVERT, READ, HOLD, DONE. Strobes are registered, one-hot, never overlap.
//  - IDLE: if start=1, latch expose_len (0 treated as 1) and enter ERASE on the next cycle. start outside IDLE is ignored.
//  - ERASE: erase=1 for exactly C_ERASE cycles, then EXPOSE.
//  - EXPOSE: expose=1 for exactly the latched exposure length, then CONVERT.
//  - CONVERT:
//      - convert=1 and bus_oe=1 for C_CONVERT cycles.
//      - bus_dout=0 on the first convert cycle, +1 per cycle; saturates at 2^DW-1, never wraps.
//      - bus_dout=0 whenever convert=0.
//  - READ (group g, from 0): read[g]=1 for C_READ cycles.
//      - bus_din is sampled on the last of these cycles.
//      - Next cycle: pix_valid=1, pix_data=sample, pix_group=g; state goes to HOLD.
//  - HOLD: read[g] stays 1 and pix_valid/pix_data/pix_group are held stable until a cycle with pix_ready=1.
//      - If g<3: on that edge, pix_valid drops and READ starts for g+1.
//      - If g==3: enter DONE.
//  - DONE: done=1 for one cycle, busy=0 next cycle, then IDLE.
//  - pix_ready while pix_valid=0 has no effect. Latency from start to first pix_valid = 1+C_ERASE+len+C_CONVERT+C_READ.
//  - abort=1 in any non-IDLE state: all strobes and pix_valid drop next cycle, state becomes IDLE, done is not pulsed.
//  - Priority: abort beats start when both are asserted. abort in IDLE is a no-op.
//  - Reset mid-frame: immediate async clear to the reset values; no partial handshake survives.
// CONFIGURATION
//  - `PFS_FRAME_TAG_EN` defined:
//      - Adds output frame_id[7:0]: 0 at reset, +1 (wrapping 255->0) on every done pulse.
//      - frame_id is held stable during a frame; aborted frames do not increment it.
//  - Not defined: no frame_id port, no counter logic.
// STRUCTURE
//  - Package pixel_seq_pkg:
//      - state enum typedef.
//      - localparam NUM_GROUPS=4.
//      - group index typedef logic[1:0].
//  - One sub-module, pfs_ramp_counter: DW-bit saturating counter with clear/enable, used for the ADC ramp.
//  - Phase length counting stays inline in the FSM.
// TESTING
//  - Nominal frame, expose_len=10, bus_din echoes a per-group constant, pix_ready=1:
//      - erase high 5 cycles, expose 10, convert 255.
//      - bus_dout runs 0..254.
//      - 4 samples with pix_group 0,1,2,3, then done pulse.
//  - Backpressure: pix_ready=0 for 7 cycles on group 1 -> read[1], pix_valid and pix_data stable all 7 cycles; group 2 starts the cycle after ready.
//  - expose_len=0 -> expose high exactly 1 cycle. Changing expose_len mid-frame has no effect.
//  - C_CONVERT=256 -> bus_dout reaches 255 and holds, no wrap to 0. bus_oe drops with convert.
//  - abort during CONVERT, and separately during HOLD -> all strobes 0 next cycle, busy=0, no done. A following start runs a full clean frame.
//  - reset asserted during EXPOSE -> outputs 0 asynchronously. `PFS_FRAME_TAG_EN`: 3 completed frames -> frame_id=3; an aborted frame leaves it unchanged.

Source files
------------

// File: rtl/pixel_seq_pkg.sv
// Shared types for the pixel frame sequencer: FSM state encoding and read-group helpers.
package pixel_seq_pkg;

    localparam int unsigned NUM_GROUPS = 4;

    typedef logic [1:0] group_t;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StErase   = 3'd1,
        StExpose  = 3'd2,
        StConvert = 3'd3,
        StRead    = 3'd4,
        StHold    = 3'd5,
        StDone    = 3'd6
    } state_e;

    function automatic logic [NUM_GROUPS-1:0] group_onehot(input group_t g);
        logic [NUM_GROUPS-1:0] v;
        v    = '0;
        v[g] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pfs_ramp_counter.sv
// Saturating up-counter used as the ADC digital ramp; clear has priority over enable.
module pfs_ramp_counter #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [DW-1:0] count
);

    logic [DW-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != {DW{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pixel_frame_sequencer.sv
// Frame controller: erase -> expose -> convert (ADC ramp on bus) -> read0..read3 with valid/ready.
// Optional frame_id output enabled by defining PFS_FRAME_TAG_EN.
module pixel_frame_sequencer
    import pixel_seq_pkg::*;
#(
    parameter int unsigned C_ERASE   = 5,
    parameter int unsigned C_CONVERT = 255,
    parameter int unsigned C_READ    = 5,
    parameter int unsigned DW        = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [15:0]           expose_len,
    output logic                  busy,
    output logic                  done,
    output logic                  erase,
    output logic                  expose,
    output logic                  convert,
    output logic [NUM_GROUPS-1:0] read,
    output logic                  bus_oe,
    output logic [DW-1:0]         bus_dout,
    input  logic [DW-1:0]         bus_din,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [DW-1:0]         pix_data,
    output logic [1:0]            pix_group
`ifdef PFS_FRAME_TAG_EN
    ,
    output logic [7:0]            frame_id
`endif
);

    localparam logic [15:0] ERASE_LAST   = 16'(C_ERASE - 1);
    localparam logic [15:0] CONVERT_LAST = 16'(C_CONVERT - 1);
    localparam logic [15:0] READ_LAST    = 16'(C_READ - 1);
    localparam group_t      LAST_GROUP   = group_t'(NUM_GROUPS - 1);

    state_e                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [15:0]           len_q, len_d;
    group_t                group_q, group_d;
    logic                  pix_valid_q, pix_valid_d;
    logic [DW-1:0]         pix_data_q, pix_data_d;
    logic                  busy_q, done_q, erase_q, expose_q, convert_q;
    logic [NUM_GROUPS-1:0] read_q;
    logic                  ramp_clr, ramp_en;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        len_d       = len_q;
        group_d     = group_q;
        pix_valid_d = pix_valid_q;
        pix_data_d  = pix_data_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start) begin
                    state_d = StErase;
                    len_d   = (expose_len == 16'd0) ? 16'd1 : expose_len;
                    group_d = '0;
                end
            end
            StErase: begin
                if (cnt_q == ERASE_LAST) begin
                    state_d = StExpose;
                    cnt_d   = '0;
                end
            end
            StExpose: begin
                if (cnt_q == len_q - 16'd1) begin
                    state_d = StConvert;
                    cnt_d   = '0;
                end
            end
            StConvert: begin
                if (cnt_q == CONVERT_LAST) begin
                    state_d = StRead;
                    cnt_d   = '0;
                end
            end
            StRead: begin
                if (cnt_q == READ_LAST) begin
                    state_d     = StHold;
                    cnt_d       = '0;
                    pix_valid_d = 1'b1;
                    pix_data_d  = bus_din;
                end
            end
            StHold: begin
                cnt_d = '0;
                if (pix_ready) begin
                    pix_valid_d = 1'b0;
                    if (group_q == LAST_GROUP) begin
                        state_d = StDone;
                    end else begin
                        group_d = group_q + 2'd1;
                        state_d = StRead;
                    end
                end
            end
            StDone: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
        if (abort && (state_q != StIdle)) begin
            state_d     = StIdle;
            cnt_d       = '0;
            pix_valid_d = 1'b0;
        end
    end

    // Strobes are registered from the next state so they change exactly on the state edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            len_q       <= '0;
            group_q     <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            erase_q     <= 1'b0;
            expose_q    <= 1'b0;
            convert_q   <= 1'b0;
            read_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            group_q     <= group_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            busy_q      <= (state_d != StIdle);
            done_q      <= (state_d == StDone);
            erase_q     <= (state_d == StErase);
            expose_q    <= (state_d == StExpose);
            convert_q   <= (state_d == StConvert);
            read_q      <= ((state_d == StRead) || (state_d == StHold)) ?
                           group_onehot(group_d) : '0;
        end
    end

    // Ramp restarts at 0 on the first convert cycle and is forced to 0 outside convert.
    assign ramp_clr = !((state_q == StConvert) && (state_d == StConvert));
    assign ramp_en  = (state_d == StConvert);

    pfs_ramp_counter #(
        .DW(DW)
    ) u_ramp (
        .clk  (clk),
        .reset(reset),
        .clr  (ramp_clr),
        .en   (ramp_en),
        .count(bus_dout)
    );

`ifdef PFS_FRAME_TAG_EN
    logic [7:0] frame_id_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_id_q <= '0;
        end else if (state_d == StDone) begin
            frame_id_q <= frame_id_q + 8'd1;
        end
    end

    assign frame_id = frame_id_q;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign erase     = erase_q;
    assign expose    = expose_q;
    assign convert   = convert_q;
    assign read      = read_q;
    assign bus_oe    = convert_q;
    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_data_q;
    assign pix_group = group_q;

endmodule
